// File: rtl/mem_bus_stage.sv
// MEM stage: runs loads/stores as single Wishbone-style cycles (IDLE/BUSY/DONE) with an ack watchdog.
// Min 3 cycles per memory op, 0 for other ops; stalls upstream while a cycle is in flight, holds DONE under stall_wb.
module mem_bus_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  mem_write_reg_address_input,
  input  logic        mem_write_reg_enable_input,
  input  logic [31:0] mem_write_reg_data_input,
  input  logic [31:0] mem_hi_input,
  input  logic [31:0] mem_lo_input,
  input  logic        mem_whilo_input,
  input  logic [7:0]  mem_aluop_input,
  input  logic [31:0] mem_memory_address_input,
  input  logic [31:0] mem_reg2_input,
  input  logic        flush,
  input  logic        stall_wb,
  output logic [4:0]  wb_write_reg_address_output,
  output logic        wb_write_reg_enable_output,
  output logic [31:0] wb_write_reg_data_output,
  output logic [31:0] wb_hi_output,
  output logic [31:0] wb_lo_output,
  output logic        wb_whilo_output,
  output logic        stall_request,
  output logic        misaligned_exception,
  output logic        bus_error,
  output logic [31:0] bus_address_output,
  output logic [31:0] bus_data_output,
  output logic [3:0]  bus_select_output,
  output logic        bus_write_enable_output,
  output logic        bus_cycle_output,
  output logic        bus_strobe_output,
  input  logic [31:0] bus_data_input,
  input  logic        bus_ack_input
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [4:0]  NOP_REGISTER_ADDRESS = 5'd0;
  localparam logic        WRITE_DISABLE        = 1'b0;
  localparam logic [31:0] ZERO_WORD            = 32'd0;
  localparam logic [7:0]  WATCHDOG_LAST        = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  watchdog;
  logic        aborted;
  logic [31:0] read_buffer;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        misaligned;
  logic        req;
  logic [1:0]  offset;
  logic [3:0]  select_next;
  logic [31:0] data_next;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  assign offset = mem_memory_address_input[1:0];

  // Decode: lane select and replicated store data, big-endian (offset 0 is bits 31:24).
  always_comb begin
    is_load     = 1'b0;
    is_store    = 1'b0;
    misaligned  = 1'b0;
    select_next = 4'b0000;
    data_next   = 32'd0;
    case (mem_aluop_input)
      EXE_LB_OP, EXE_LBU_OP: begin
        is_load     = 1'b1;
        select_next = 4'b1000 >> offset;
      end
      EXE_LH_OP, EXE_LHU_OP: begin
        is_load     = 1'b1;
        misaligned  = offset[0];
        select_next = offset[1] ? 4'b0011 : 4'b1100;
      end
      EXE_LW_OP: begin
        is_load     = 1'b1;
        misaligned  = |offset;
        select_next = 4'b1111;
      end
      EXE_SB_OP: begin
        is_store    = 1'b1;
        select_next = 4'b1000 >> offset;
        data_next   = {4{mem_reg2_input[7:0]}};
      end
      EXE_SH_OP: begin
        is_store    = 1'b1;
        misaligned  = offset[0];
        select_next = offset[1] ? 4'b0011 : 4'b1100;
        data_next   = {2{mem_reg2_input[15:0]}};
      end
      EXE_SW_OP: begin
        is_store    = 1'b1;
        misaligned  = |offset;
        select_next = 4'b1111;
        data_next   = mem_reg2_input;
      end
      default: ;
    endcase
  end

  assign is_mem = is_load | is_store;
  assign req    = is_mem & ~misaligned & ~flush;

  always_comb begin
    case (offset)
      2'd0:    load_byte = read_buffer[31:24];
      2'd1:    load_byte = read_buffer[23:16];
      2'd2:    load_byte = read_buffer[15:8];
      default: load_byte = read_buffer[7:0];
    endcase
    load_half = offset[1] ? read_buffer[15:0] : read_buffer[31:16];
    case (mem_aluop_input)
      EXE_LB_OP:  load_data = {{24{load_byte[7]}}, load_byte};
      EXE_LBU_OP: load_data = {24'd0, load_byte};
      EXE_LH_OP:  load_data = {{16{load_half[15]}}, load_half};
      EXE_LHU_OP: load_data = {16'd0, load_half};
      default:    load_data = read_buffer;
    endcase
  end

  always_comb begin
    wb_write_reg_address_output = mem_write_reg_address_input;
    wb_write_reg_enable_output  = mem_write_reg_enable_input;
    wb_write_reg_data_output    = mem_write_reg_data_input;
    wb_hi_output                = mem_hi_input;
    wb_lo_output                = mem_lo_input;
    wb_whilo_output             = mem_whilo_input;
    if (reset) begin
      wb_write_reg_address_output = NOP_REGISTER_ADDRESS;
      wb_write_reg_enable_output  = WRITE_DISABLE;
      wb_write_reg_data_output    = ZERO_WORD;
      wb_hi_output                = ZERO_WORD;
      wb_lo_output                = ZERO_WORD;
      wb_whilo_output             = WRITE_DISABLE;
    end else if (is_mem) begin
      // Only a completed, aligned, non-aborted load writes the GPR.
      wb_write_reg_data_output   = load_data;
      wb_write_reg_enable_output = is_load & ~misaligned & ~aborted & (state == DONE)
                                   & mem_write_reg_enable_input;
    end
  end

  assign stall_request        = ~reset & (((state == IDLE) & req) | ((state == BUSY) & ~flush));
  assign misaligned_exception = ~reset & misaligned;

  always_ff @(posedge clock) begin
    if (reset) begin
      state                   <= IDLE;
      watchdog                <= 8'd0;
      aborted                 <= 1'b0;
      read_buffer             <= 32'd0;
      bus_error               <= 1'b0;
      bus_address_output      <= 32'd0;
      bus_data_output         <= 32'd0;
      bus_select_output       <= 4'd0;
      bus_write_enable_output <= 1'b0;
      bus_cycle_output        <= 1'b0;
      bus_strobe_output       <= 1'b0;
    end else begin
      bus_error <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state                   <= BUSY;
            watchdog                <= 8'd0;
            aborted                 <= 1'b0;
            bus_cycle_output        <= 1'b1;
            bus_strobe_output       <= 1'b1;
            bus_write_enable_output <= is_store;
            bus_select_output       <= select_next;
            bus_address_output      <= {mem_memory_address_input[31:2], 2'b00};
            bus_data_output         <= data_next;
          end
        end
        BUSY: begin
          if (flush) begin
            state                   <= IDLE;
            bus_cycle_output        <= 1'b0;
            bus_strobe_output       <= 1'b0;
            bus_write_enable_output <= 1'b0;
          end else if (bus_ack_input) begin
            state                   <= DONE;
            read_buffer             <= bus_data_input;
            bus_cycle_output        <= 1'b0;
            bus_strobe_output       <= 1'b0;
            bus_write_enable_output <= 1'b0;
          end else if (watchdog == WATCHDOG_LAST) begin
            state                   <= DONE;
            aborted                 <= 1'b1;
            bus_error               <= 1'b1;
            bus_cycle_output        <= 1'b0;
            bus_strobe_output       <= 1'b0;
            bus_write_enable_output <= 1'b0;
          end else begin
            watchdog <= watchdog + 8'd1;
          end
        end
        DONE: begin
          // Inputs still carry the finished op here; leaving for IDLE must not re-issue it.
          if (!stall_wb) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_stage.sv
// Randomized scoreboard bench for mem_bus_stage: driver pushes expected MEM/WB results and bus cycles,
// independent monitors and a bus slave model check what the DUT presents.
module tb_mem_bus_stage;

  localparam int TIMEOUT = 16;

  localparam logic [7:0] OP_LB  = 8'hE0, OP_LBU = 8'hE4, OP_LH = 8'hE1, OP_LHU = 8'hE5;
  localparam logic [7:0] OP_LW  = 8'hE3, OP_SB  = 8'hE8, OP_SH = 8'hE9, OP_SW  = 8'hEB;
  localparam logic [7:0] OP_NOP = 8'h00, OP_ADD = 8'h20, OP_ADDU = 8'h21, OP_OR = 8'h25;

  typedef struct {
    logic [4:0]  rd;
    logic        en;
    logic [31:0] data;
    bit          chk_data;
    logic        mis;
    int          stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
  } wexp_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    bit          chk_dat;
    logic [3:0]  sel;
    logic        we;
    int          len;
    logic        tmo;
  } bexp_t;

  typedef struct {
    int          waits;
    logic [31:0] rdata;
  } resp_t;

  logic        clock, reset;
  logic [4:0]  mem_write_reg_address_input;
  logic        mem_write_reg_enable_input;
  logic [31:0] mem_write_reg_data_input, mem_hi_input, mem_lo_input;
  logic        mem_whilo_input;
  logic [7:0]  mem_aluop_input;
  logic [31:0] mem_memory_address_input, mem_reg2_input;
  logic        flush, stall_wb;
  logic [4:0]  wb_write_reg_address_output;
  logic        wb_write_reg_enable_output;
  logic [31:0] wb_write_reg_data_output, wb_hi_output, wb_lo_output;
  logic        wb_whilo_output, stall_request, misaligned_exception, bus_error;
  logic [31:0] bus_address_output, bus_data_output;
  logic [3:0]  bus_select_output;
  logic        bus_write_enable_output, bus_cycle_output, bus_strobe_output;
  logic [31:0] bus_data_input;
  logic        bus_ack_input;

  wexp_t wq[$];
  bexp_t bq[$];
  resp_t rq[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    stall_cnt = 0;
  bit    mon_en = 0, sw_en = 0, slave_en = 0;

  mem_bus_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .mem_write_reg_address_input(mem_write_reg_address_input),
    .mem_write_reg_enable_input(mem_write_reg_enable_input),
    .mem_write_reg_data_input(mem_write_reg_data_input),
    .mem_hi_input(mem_hi_input), .mem_lo_input(mem_lo_input),
    .mem_whilo_input(mem_whilo_input), .mem_aluop_input(mem_aluop_input),
    .mem_memory_address_input(mem_memory_address_input),
    .mem_reg2_input(mem_reg2_input), .flush(flush), .stall_wb(stall_wb),
    .wb_write_reg_address_output(wb_write_reg_address_output),
    .wb_write_reg_enable_output(wb_write_reg_enable_output),
    .wb_write_reg_data_output(wb_write_reg_data_output),
    .wb_hi_output(wb_hi_output), .wb_lo_output(wb_lo_output),
    .wb_whilo_output(wb_whilo_output), .stall_request(stall_request),
    .misaligned_exception(misaligned_exception), .bus_error(bus_error),
    .bus_address_output(bus_address_output), .bus_data_output(bus_data_output),
    .bus_select_output(bus_select_output),
    .bus_write_enable_output(bus_write_enable_output),
    .bus_cycle_output(bus_cycle_output), .bus_strobe_output(bus_strobe_output),
    .bus_data_input(bus_data_input), .bus_ack_input(bus_ack_input)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic set_inputs(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                            input logic [31:0] alu, input logic [4:0] rd, input logic en,
                            input logic [31:0] hi, input logic [31:0] lo, input logic whilo);
    mem_aluop_input             = op;
    mem_memory_address_input    = addr;
    mem_reg2_input              = reg2;
    mem_write_reg_data_input    = alu;
    mem_write_reg_address_input = rd;
    mem_write_reg_enable_input  = en;
    mem_hi_input                = hi;
    mem_lo_input                = lo;
    mem_whilo_input             = whilo;
  endtask

  // Reference model: size/sign from the opcode, lanes and extraction by byte arithmetic.
  task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                       input logic [31:0] alu, input logic [4:0] rd, input logic en,
                       input int waits, input logic [31:0] rdata);
    wexp_t e; bexp_t b; resp_t r;
    int size, off, len, n;
    bit ld, sgn;
    logic [31:0] v, hi, lo;
    logic whilo;
    size = 0; ld = 0; sgn = 0;
    case (op)
      OP_LB:  begin size = 1; ld = 1; sgn = 1; end
      OP_LBU: begin size = 1; ld = 1; end
      OP_LH:  begin size = 2; ld = 1; sgn = 1; end
      OP_LHU: begin size = 2; ld = 1; end
      OP_LW:  begin size = 4; ld = 1; end
      OP_SB:  size = 1;
      OP_SH:  size = 2;
      OP_SW:  size = 4;
      default: ;
    endcase
    off = int'(addr & 32'd3);
    hi = $urandom; lo = $urandom; whilo = 1'($urandom_range(1));
    e.rd = rd; e.hi = hi; e.lo = lo; e.whilo = whilo;
    e.mis = 1'b0; e.stall = 0; e.chk_data = 1; e.data = alu; e.en = en;
    if (size != 0) begin
      if (off % size != 0) begin
        e.mis = 1'b1; e.en = 1'b0; e.chk_data = 0;
      end else begin
        len = (waits + 1 < TIMEOUT) ? waits + 1 : TIMEOUT;
        b.len = len; b.tmo = (waits >= TIMEOUT);
        b.adr = addr & 32'hFFFF_FFFC; b.we = !ld; b.chk_dat = !ld;
        if (size == 1) begin
          b.sel = 4'(1 << (3 - off));
          b.dat = {24'd0, reg2[7:0]} * 32'h0101_0101;
          v = (rdata >> (8 * (3 - off))) & 32'hFF;
          if (sgn && v[7]) v = v - 32'd256;
        end else if (size == 2) begin
          b.sel = (off == 0) ? 4'b1100 : 4'b0011;
          b.dat = {16'd0, reg2[15:0]} * 32'h0001_0001;
          v = (rdata >> (8 * (2 - off))) & 32'hFFFF;
          if (sgn && v[15]) v = v - 32'h10000;
        end else begin
          b.sel = 4'b1111; b.dat = reg2; v = rdata;
        end
        e.data = v;
        e.chk_data = ld && !b.tmo;
        e.en = ld && !b.tmo && en;
        e.stall = 1 + len;
        r.waits = waits; r.rdata = rdata;
        bq.push_back(b);
        rq.push_back(r);
      end
    end
    wq.push_back(e);
    set_inputs(op, addr, reg2, alu, rd, en, hi, lo, whilo);
    n = 0;
    do begin @(negedge clock); n++; end while ((stall_request || stall_wb) && n < 200);
    if (n >= 200) begin n_checks++; $display("FAIL op_timeout: op %h never presented after %0d cycles", op, n); end
    @(posedge clock); #1;
  endtask

  initial begin : stall_gen
    stall_wb = 1'b0;
    forever begin
      @(posedge clock); #1;
      stall_wb = sw_en && ($urandom_range(3) == 0);
    end
  end

  initial begin : bus_slave
    resp_t r; int scnt; bit act;
    bus_ack_input = 1'b0; bus_data_input = 32'd0; act = 0; scnt = 0;
    r.waits = 1000; r.rdata = 32'd0;
    forever begin
      @(negedge clock);
      if (slave_en) begin
        if (bus_cycle_output && bus_strobe_output) begin
          if (!act) begin
            if (rq.size() > 0) r = rq.pop_front();
            else begin r.waits = 1000; r.rdata = 32'd0; end
            scnt = 0; act = 1;
          end
          bus_ack_input  = (scnt == r.waits);
          bus_data_input = bus_ack_input ? r.rdata : $urandom;
          scnt++;
        end else begin
          act = 0; bus_ack_input = 1'b0;
        end
      end
    end
  end

  initial begin : wb_monitor
    wexp_t e;
    forever begin
      @(negedge clock);
      if (mon_en && !reset) begin
        if (stall_request) stall_cnt++;
        else if (!stall_wb) begin
          if (wq.size() == 0) begin
            n_checks++; $display("FAIL wb_unexpected: result presented with nothing outstanding");
          end else begin
            e = wq.pop_front();
            check("wb_addr", 32'(wb_write_reg_address_output), 32'(e.rd));
            check("wb_enable", 32'(wb_write_reg_enable_output), 32'(e.en));
            if (e.chk_data) check("wb_data", wb_write_reg_data_output, e.data);
            check("wb_hi", wb_hi_output, e.hi);
            check("wb_lo", wb_lo_output, e.lo);
            check("wb_whilo", 32'(wb_whilo_output), 32'(e.whilo));
            check("misaligned", 32'(misaligned_exception), 32'(e.mis));
            check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
          end
          stall_cnt = 0;
        end
      end
    end
  end

  initial begin : bus_monitor
    bexp_t b; int len; bit prev;
    prev = 0; len = 0; b.len = 0; b.tmo = 1'b0;
    forever begin
      @(negedge clock);
      if (mon_en && !reset) begin
        if (bus_cycle_output && !prev) begin
          if (bq.size() == 0) begin
            n_checks++; $display("FAIL bus_unexpected: cycle at %h, none expected", bus_address_output);
            b.len = 0; b.tmo = 1'b0;
          end else begin
            b = bq.pop_front();
            check("bus_addr", bus_address_output, b.adr);
            check("bus_sel", 32'(bus_select_output), 32'(b.sel));
            check("bus_we", 32'(bus_write_enable_output), 32'(b.we));
            check("bus_stb", 32'(bus_strobe_output), 32'd1);
            if (b.chk_dat) check("bus_data", bus_data_output, b.dat);
          end
          len = 1;
        end else if (bus_cycle_output) begin
          len++;
        end else if (prev) begin
          check("bus_cycle_len", 32'(len), 32'(b.len));
          check("bus_error_pulse", 32'(bus_error), 32'(b.tmo));
        end else if (bus_error) begin
          n_checks++; $display("FAIL bus_error_spurious: bus_error high outside abort cycle");
        end
      end
      prev = bus_cycle_output;
    end
  end

  initial begin : main
    logic [7:0] ops [12];
    logic [7:0] op;
    logic [31:0] addr;
    int r, waits;
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_NOP, OP_ADD, OP_ADDU, OP_OR};
    reset = 1'b1; flush = 1'b0;
    set_inputs(OP_LW, 32'h3001, 32'h55, 32'hDEAD_BEEF, 5'd9, 1'b1, 32'h1, 32'h2, 1'b1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_stall", 32'(stall_request), 32'd0);
    check("reset_misaligned", 32'(misaligned_exception), 32'd0);
    check("reset_wb_enable", 32'(wb_write_reg_enable_output), 32'd0);
    check("reset_wb_addr", 32'(wb_write_reg_address_output), 32'd0);
    check("reset_wb_data", wb_write_reg_data_output, 32'd0);
    check("reset_wb_hi", wb_hi_output, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    set_inputs(OP_NOP, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clock);
    check("reset_bus_idle", {bus_address_output, bus_data_output, 28'd0, bus_select_output},
          32'd0);
    check("reset_bus_ctrl", 32'({bus_cycle_output, bus_strobe_output, bus_write_enable_output, bus_error}),
          32'd0);
    @(posedge clock); #1;
    slave_en = 1; mon_en = 1;

    do_op(OP_ADD, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 1'b1, 0, 32'h0);
    do_op(OP_LB,  32'h1003, 32'h0, 32'h0, 5'd7, 1'b1, 2, 32'hAABB_CC80);
    do_op(OP_LBU, 32'h1003, 32'h0, 32'h0, 5'd7, 1'b1, 2, 32'hAABB_CC80);
    do_op(OP_SH,  32'h2002, 32'h0000_BEEF, 32'h0, 5'd3, 1'b1, 0, 32'h0);
    do_op(OP_LW,  32'h3001, 32'h0, 32'h0, 5'd4, 1'b1, 0, 32'h0);
    do_op(OP_LW,  32'h3000, 32'h0, 32'h0, 5'd4, 1'b1, TIMEOUT, 32'h1111_2222);
    do_op(OP_LW,  32'h3004, 32'h0, 32'h0, 5'd4, 1'b1, TIMEOUT - 1, 32'h3333_4444);

    sw_en = 1;
    for (int i = 0; i < 250; i++) begin
      op = ops[$urandom_range(11)];
      addr = $urandom;
      if ($urandom_range(3) != 0) addr = (op == OP_LH || op == OP_LHU || op == OP_SH) ? (addr & 32'hFFFF_FFFE)
                                         : (op == OP_LW || op == OP_SW) ? (addr & 32'hFFFF_FFFC) : addr;
      r = int'($urandom_range(15));
      waits = (r < 12) ? int'($urandom_range(3)) : (r < 14) ? TIMEOUT - 1 : TIMEOUT + int'($urandom_range(2));
      do_op(op, addr, $urandom, $urandom, 5'($urandom_range(31)), 1'($urandom_range(1)), waits, $urandom);
    end

    mon_en = 0; sw_en = 0;
    repeat (2) @(posedge clock);
    #1;
    slave_en = 0; bus_ack_input = 1'b0;
    check("wb_queue_drained", 32'(wq.size()), 32'd0);
    check("bus_queue_drained", 32'(bq.size()), 32'd0);

    // Flush in the second BUSY cycle, then a late ack while IDLE.
    set_inputs(OP_LW, 32'h4000, 32'h0, 32'h0, 5'd6, 1'b1, 32'h0, 32'h0, 1'b0);
    @(negedge clock);
    check("flush_issue_stall", 32'(stall_request), 32'd1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    flush = 1'b1;
    @(negedge clock);
    check("flush_stall_drop", 32'(stall_request), 32'd0);
    check("flush_cyc_still_up", 32'(bus_cycle_output), 32'd1);
    @(posedge clock); #1;
    flush = 1'b0;
    set_inputs(OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    bus_ack_input = 1'b1; bus_data_input = 32'hBAD0_BAD0;
    @(negedge clock);
    check("flush_bus_dropped", 32'({bus_cycle_output, bus_strobe_output, bus_write_enable_output}), 32'd0);
    check("flush_idle_stall", 32'(stall_request), 32'd0);
    @(posedge clock); #1;
    bus_ack_input = 1'b0;
    @(negedge clock);
    check("late_ack_ignored", 32'({bus_cycle_output, bus_error}), 32'd0);
    @(posedge clock); #1;
    set_inputs(OP_LW, 32'h5000, 32'h0, 32'h0, 5'd6, 1'b1, 32'h0, 32'h0, 1'b0);
    @(negedge clock);
    check("idle_after_flush", 32'(stall_request), 32'd1);
    @(posedge clock); #1;
    @(negedge clock);
    check("reissue_cyc", 32'(bus_cycle_output), 32'd1);

    // Reset asserted mid-BUSY.
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("reset_busy_stall", 32'(stall_request), 32'd0);
    check("reset_busy_wb_en", 32'(wb_write_reg_enable_output), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("reset_busy_bus", bus_address_output | bus_data_output, 32'd0);
    check("reset_busy_ctrl", 32'({bus_select_output, bus_cycle_output, bus_strobe_output,
                                  bus_write_enable_output, bus_error}), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    set_inputs(OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clock);
    check("post_reset_idle", 32'({bus_cycle_output, stall_request}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
